// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - TinyALU bus opcodes, illegal-opcode range and responder FSM states
package tinyalu_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100
   } operation_t;

   // Bus codes from here up are illegal; the TLM-side rst_op is never driven on the 3-bit bus.
   localparam logic [2:0] ILLEGAL_OP_MIN = 3'b101;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      EXEC     = 2'b01,
      MUL      = 2'b10,
      WAIT_LOW = 2'b11
   } state_t;

   function automatic logic is_illegal_op(input logic [2:0] op_bits);
      return op_bits >= ILLEGAL_OP_MIN;
   endfunction

endpackage

// File: rtl/tinyalu_mult_pipe.sv
// rtl/tinyalu_mult_pipe.sv - unsigned multiplier with MUL_LATENCY-1 product stages and a matching valid chain
module tinyalu_mult_pipe
   import tinyalu_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int MUL_LATENCY = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_flush,
   input  logic                i_valid,
   input  logic [DATA_W-1:0]   i_a,
   input  logic [DATA_W-1:0]   i_b,
   output logic                o_valid,
   output logic [2*DATA_W-1:0] o_product
);

   localparam int STAGES = MUL_LATENCY - 1;

   logic [STAGES-1:0]   r_valid;
   logic [2*DATA_W-1:0] r_prod [STAGES];
   logic [2*DATA_W-1:0] w_a_ext;
   logic [2*DATA_W-1:0] w_b_ext;

   assign w_a_ext = {{DATA_W{1'b0}}, i_a};
   assign w_b_ext = {{DATA_W{1'b0}}, i_b};

   // Only the valid chain is reset/flushed; product data is meaningless without it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_flush) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= i_valid;
         for (int i = 1; i < STAGES; i++) begin
            r_valid[i] <= r_valid[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      r_prod[0] <= w_a_ext * w_b_ext;
      for (int i = 1; i < STAGES; i++) begin
         r_prod[i] <= r_prod[i-1];
      end
   end

   assign o_valid   = r_valid[STAGES-1];
   assign o_product = r_prod[STAGES-1];

endmodule

// File: rtl/tinyalu_responder.sv
// rtl/tinyalu_responder.sv - TinyALU start/done responder; err port exists only with TINYALU_ILLEGAL_OP_ERR_EN
module tinyalu_responder
   import tinyalu_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int MUL_LATENCY = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [2:0]          op,
   input  logic [DATA_W-1:0]   A,
   input  logic [DATA_W-1:0]   B,
   output logic                done,
   output logic [2*DATA_W-1:0] result
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
   ,
   output logic                err
`endif
);

   if (MUL_LATENCY < 2 || MUL_LATENCY > 8) begin : g_bad_latency
      $error("tinyalu_responder: MUL_LATENCY must be within 2..8");
   end

   function automatic logic [2*DATA_W-1:0] exec_result(input logic [2:0]        f_op,
                                                       input logic [DATA_W-1:0] f_a,
                                                       input logic [DATA_W-1:0] f_b);
      logic [DATA_W:0] sum;
      sum = {1'b0, f_a} + {1'b0, f_b};
      case (f_op)
         add_op:  return {{(DATA_W-1){1'b0}}, sum};
         and_op:  return {{DATA_W{1'b0}}, f_a & f_b};
         xor_op:  return {{DATA_W{1'b0}}, f_a ^ f_b};
         default: return '0;
      endcase
   endfunction

   state_t              r_state;
   logic [2:0]          r_op;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic                r_done;
   logic [2*DATA_W-1:0] r_result;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
   logic                r_err;
`endif

   logic                w_mul_start;
   logic                w_abort;
   logic                w_mul_valid;
   logic [2*DATA_W-1:0] w_mul_product;
   logic [2*DATA_W-1:0] w_exec_result;

   // The multiplier takes operands straight off the bus on the sampling edge.
   assign w_mul_start   = (r_state == IDLE) && start && (op == mul_op);
   assign w_abort       = (r_state == MUL) && !start;
   assign w_exec_result = exec_result(r_op, r_a, r_b);

   tinyalu_mult_pipe #(
      .DATA_W      (DATA_W),
      .MUL_LATENCY (MUL_LATENCY)
   ) u_mult_pipe (
      .clk       (clk),
      .reset     (reset),
      .i_flush   (w_abort),
      .i_valid   (w_mul_start),
      .i_a       (A),
      .i_b       (B),
      .o_valid   (w_mul_valid),
      .o_product (w_mul_product)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
         r_err    <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
         r_err  <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op <= op;
                  r_a  <= A;
                  r_b  <= B;
                  if (op == mul_op) begin
                     r_state <= MUL;
                  end else if (op != no_op) begin
                     r_state <= EXEC;
                  end
               end
            end
            EXEC: begin
               r_done   <= 1'b1;
               r_result <= w_exec_result;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
               r_err    <= is_illegal_op(r_op);
`endif
               r_state  <= WAIT_LOW;
            end
            MUL: begin
               // A dropped start means the initiator gave up; that wins over a same-edge completion.
               if (!start) begin
                  r_state <= IDLE;
               end else if (w_mul_valid) begin
                  r_done   <= 1'b1;
                  r_result <= w_mul_product;
                  r_state  <= WAIT_LOW;
               end
            end
            WAIT_LOW: begin
               if (!start) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign done   = r_done;
   assign result = r_result;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
   assign err    = r_err;
`endif

endmodule

// File: tb/tb_tinyalu_responder.sv
// tb/tb_tinyalu_responder.sv - self-checking bench for tinyalu_responder, follows TINYALU_ILLEGAL_OP_ERR_EN
`timescale 1ns/1ps
module tb_tinyalu_responder;

   localparam int LAT = 3;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic        start  = 1'b0;
   logic [2:0]  op     = 3'b000;
   logic [7:0]  A      = 8'h00;
   logic [7:0]  B      = 8'h00;
   logic        done;
   logic [15:0] result;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
   logic        err;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tinyalu_responder #(
      .DATA_W      (8),
      .MUL_LATENCY (LAT)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .done   (done),
      .result (result)
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
      ,
      .err    (err)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_val(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      case (o)
         3'd1:    return 16'(a) + 16'(b);
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   // Reference model: a command is owed a done at a computed edge; after done the responder ignores start until it falls.
   bit          m_pending  = 0;
   bit          m_wait_low = 0;
   bit          m_is_mul   = 0;
   bit          m_ill      = 0;
   int          edge_cnt   = 0;
   int          m_due      = 0;
   logic [15:0] m_val      = '0;
   logic        exp_done   = 1'b0;
   logic        exp_err    = 1'b0;
   logic [15:0] exp_result = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pending  = 0;
         m_wait_low = 0;
         exp_done   = 1'b0;
         exp_err    = 1'b0;
         exp_result = '0;
      end else begin
         edge_cnt++;
         exp_done = 1'b0;
         exp_err  = 1'b0;
         if (m_pending) begin
            if (m_is_mul && !start) begin
               m_pending = 0;
            end else if (edge_cnt == m_due) begin
               exp_done   = 1'b1;
               exp_result = m_val;
               exp_err    = m_ill;
               m_pending  = 0;
               m_wait_low = 1;
            end
         end else if (m_wait_low) begin
            if (!start) m_wait_low = 0;
         end else if (start && op != 3'd0) begin
            m_pending = 1;
            m_is_mul  = (op == 3'd4);
            m_ill     = (op >= 3'd5);
            m_due     = edge_cnt + ((op == 3'd4) ? LAT - 1 : 1);
            m_val     = ref_val(op, A, B);
         end
      end
   end

   bit chk_en = 0;
   int cyc    = 0;
   int done_cycles[$];

   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         chk("cyc_done", {31'd0, done}, {31'd0, exp_done});
         chk("cyc_result", {16'd0, result}, {16'd0, exp_result});
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
         chk("cyc_err", {31'd0, err}, {31'd0, exp_err});
`endif
         if (done === 1'b1) done_cycles.push_back(cyc);
      end
   end

   task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input int extra_hold, input bit chg_a,
                       output logic [15:0] res, output int k_done, output int pulses,
                       output logic err_seen);
      res      = '0;
      k_done   = 0;
      pulses   = 0;
      err_seen = 1'b0;
      @(negedge clk);
      #1;
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            if (k_done == 0) begin
               k_done = k;
               res    = result;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
               err_seen = err;
`endif
            end
         end
         if (k_done != 0 && k >= k_done + 1 + extra_hold) break;
         if (k == 1 && chg_a) begin
            #1;
            A = 8'h00;
         end
      end
      #1;
      start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] res;
      logic        e;
      int          k;
      int          p;
      int          gap;

      repeat (2) @(negedge clk);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_result", {16'd0, result}, 32'd0);
      #1;
      reset  = 1'b0;
      chk_en = 1;

      send(3'b001, 8'hFF, 8'h01, 3, 0, res, k, p, e);
      chk("add_result", {16'd0, res}, 32'h0100);
      chk("add_latency", k, 2);
      chk("add_pulses", p, 1);

      send(3'b100, 8'hFF, 8'hFF, 0, 1, res, k, p, e);
      chk("mul_result", {16'd0, res}, 32'hFE01);
      chk("mul_latency", k, 3);
      chk("mul_pulses", p, 1);

      p = 0;
      @(negedge clk);
      #1;
      start = 1'b1; op = 3'b000; A = 8'h12; B = 8'h34;
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) p++;
      end
      #1;
      start = 1'b0;
      chk("noop_pulses", p, 0);
      chk("noop_result", {16'd0, result}, 32'hFE01);

      p = 0;
      @(negedge clk);
      #1;
      start = 1'b1; op = 3'b100; A = 8'h10; B = 8'h10;
      @(negedge clk);
      #1;
      start = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1) p++;
      end
      chk("abort_pulses", p, 0);
      chk("abort_result", {16'd0, result}, 32'hFE01);

      @(negedge clk);
      #1;
      start = 1'b1; op = 3'b100; A = 8'h10; B = 8'h10;
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_done", {31'd0, done}, 32'd0);
      chk("async_reset_result", {16'd0, result}, 32'd0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      repeat (4) @(negedge clk);

      send(3'b111, 8'h5A, 8'hC3, 0, 0, res, k, p, e);
      chk("illegal_result", {16'd0, res}, 32'd0);
      chk("illegal_latency", k, 2);
      chk("illegal_pulses", p, 1);
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
      chk("illegal_err", {31'd0, e}, 32'd1);
`endif

      done_cycles.delete();
      send(3'b011, 8'hAA, 8'h0F, 0, 0, res, k, p, e);
      chk("b2b_xor", {16'd0, res}, 32'h00A5);
      send(3'b010, 8'hF0, 8'h3C, 0, 0, res, k, p, e);
      chk("b2b_and", {16'd0, res}, 32'h0030);
      chk("b2b_pulses", done_cycles.size(), 2);
      gap = (done_cycles.size() >= 2) ? done_cycles[1] - done_cycles[0] : 0;
      chk("b2b_gap", {31'd0, gap >= 3}, 32'd1);

      for (int it = 0; it < 300; it++) begin
         logic [2:0] ro;
         logic [7:0] ra;
         logic [7:0] rb;
         int         r;
         ro = 3'($urandom_range(0, 7));
         ra = 8'($urandom);
         rb = 8'($urandom);
         r  = $urandom_range(0, 99);
         if (ro == 3'd0) begin
            @(negedge clk);
            #1;
            start = 1'b1; op = ro; A = ra; B = rb;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #1;
            start = 1'b0;
         end else if (ro == 3'd4 && r < 15) begin
            @(negedge clk);
            #1;
            start = 1'b1; op = ro; A = ra; B = rb;
            repeat ($urandom_range(1, LAT - 2)) @(negedge clk);
            #1;
            start = 1'b0;
         end else if (ro == 3'd4 && r < 22) begin
            @(negedge clk);
            #1;
            start = 1'b1; op = ro; A = ra; B = rb;
            @(negedge clk);
            #1;
            reset = 1'b1;
            @(negedge clk);
            #1;
            reset = 1'b0;
            start = 1'b0;
         end else begin
            send(ro, ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)), res, k, p, e);
            chk("rand_done_seen", {31'd0, k > 0}, 32'd1);
            chk("rand_pulses", p, 1);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
